// File: rtl/snd_mailbox_pkg.sv
// Shared constants and sizing helpers for the sound command mailbox.
package snd_mailbox_pkg;

  localparam int unsigned BUSY_STICKY = 0;
  localparam int unsigned BUSY_LEVEL  = 1;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/snd_cmd_mailbox_if.sv
// Main-CPU strobe side and sound-CPU read/ack side of the command mailbox.
interface snd_cmd_mailbox_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NIRQ  = 1
);
  import snd_mailbox_pkg::*;

  localparam int unsigned CW = cnt_w(DEPTH);

  logic            mcode;
  logic [DW-1:0]   mdin;
  logic            snd_busy;
  logic            ovf;
  logic            rd_cmd;
  logic [DW-1:0]   cmd_dout;
  logic            cmd_valid;
  logic [CW-1:0]   cmd_count;
  logic            busy_clr;
  logic [NIRQ-1:0] irq_src;
  logic [NIRQ:0]   ack;
  logic [NIRQ:0]   pending;
  logic            int_n;

  modport master (
    output mcode, mdin, rd_cmd, busy_clr, irq_src, ack,
    input  snd_busy, ovf, cmd_dout, cmd_valid, cmd_count, pending, int_n
  );

  modport slave (
    input  mcode, mdin, rd_cmd, busy_clr, irq_src, ack,
    output snd_busy, ovf, cmd_dout, cmd_valid, cmd_count, pending, int_n
  );

endinterface

// File: rtl/snd_cmd_fifo.sv
// First-word-fall-through command FIFO; head reads as all-ones when empty.
module snd_cmd_fifo
  import snd_mailbox_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          RESETn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = ptr_w(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  // A pop frees the slot a same-cycle push needs when full; pop on empty is ignored.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= nxt(r_tail);
      if (w_pop)  r_head <= nxt(r_head);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= din;
  end

  assign dout  = empty ? '1 : r_mem[r_head];
  assign count = r_count;

endmodule

// File: rtl/snd_cmd_mailbox.sv
// Sound command mailbox: command FIFO, busy/overflow flags and IRQ pending register driving INT_n.
module snd_cmd_mailbox
  import snd_mailbox_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NIRQ      = 1,
  parameter int unsigned BUSY_MODE = BUSY_STICKY
) (
  input logic               clk,
  input logic               RESETn,
  snd_cmd_mailbox_if.slave  bus
);

  localparam int unsigned CW = cnt_w(DEPTH);

  logic            r_mcode_hist;
  logic [NIRQ-1:0] r_irq_hist;
  logic [NIRQ:0]   r_pending;
  logic            r_ovf;

  logic            w_mcode_edge;
  logic [NIRQ-1:0] w_irq_edge;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [DW-1:0]   w_dout;
  logic            w_pop_ok;
  logic            w_push_ok;
  logic            w_rearm;
  logic            w_ovf_set;
  logic [NIRQ:0]   w_pend_set;

  // History resets high so an input already asserted at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (!RESETn) begin
      r_mcode_hist <= 1'b1;
      r_irq_hist   <= '1;
    end else begin
      r_mcode_hist <= bus.mcode;
      r_irq_hist   <= bus.irq_src;
    end
  end

  assign w_mcode_edge = bus.mcode & ~r_mcode_hist;
  assign w_irq_edge   = bus.irq_src & ~r_irq_hist;

  snd_cmd_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .RESETn (RESETn),
    .push   (w_mcode_edge),
    .pop    (bus.rd_cmd),
    .din    (bus.mdin),
    .dout   (w_dout),
    .count  (w_count),
    .full   (w_full),
    .empty  (w_empty)
  );

  assign w_pop_ok   = bus.rd_cmd & ~w_empty;
  assign w_push_ok  = w_mcode_edge & (~w_full | w_pop_ok);
  assign w_ovf_set  = w_mcode_edge & w_full & ~w_pop_ok;
  // Re-arm the command interrupt while commands remain after a pop.
  assign w_rearm    = w_pop_ok & (w_count > CW'(1));
  assign w_pend_set = {w_irq_edge, w_push_ok | w_rearm};

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      r_pending <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~bus.ack) | w_pend_set;
      r_ovf     <= w_ovf_set | (r_ovf & ~bus.busy_clr);
    end
  end

  generate
    if (BUSY_MODE == BUSY_LEVEL) begin : g_busy_level
      assign bus.snd_busy = ~w_empty;
    end else begin : g_busy_sticky
      logic r_busy;
      always_ff @(posedge clk) begin
        if (!RESETn) r_busy <= 1'b0;
        else         r_busy <= w_push_ok | (r_busy & ~bus.busy_clr);
      end
      assign bus.snd_busy = r_busy;
    end
  endgenerate

  assign bus.ovf       = r_ovf;
  assign bus.cmd_dout  = w_dout;
  assign bus.cmd_valid = ~w_empty;
  assign bus.cmd_count = w_count;
  assign bus.pending   = r_pending;
  assign bus.int_n     = ~|r_pending;

endmodule

// File: tb/tb_snd_cmd_mailbox.sv
// Directed and random stimulus for the mailbox in both busy modes against a queue-based model.
module tb_snd_cmd_mailbox;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       mcode = 1'b0;
  logic [7:0] mdin = 8'h00;
  logic       rd_cmd = 1'b0;
  logic       busy_clr = 1'b0;
  logic       irq = 1'b0;
  logic [1:0] ack = 2'b00;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mq[$];
  logic [1:0] m_pend = 2'b00;
  logic       m_busy = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       m_hm   = 1'b1;
  logic       m_hirq = 1'b1;

  always #5 clk = ~clk;

  snd_cmd_mailbox_if #(.DW(8), .DEPTH(DEPTH), .NIRQ(1)) bus0 ();
  snd_cmd_mailbox_if #(.DW(8), .DEPTH(DEPTH), .NIRQ(1)) bus1 ();

  assign bus0.mcode = mcode;     assign bus1.mcode = mcode;
  assign bus0.mdin = mdin;       assign bus1.mdin = mdin;
  assign bus0.rd_cmd = rd_cmd;   assign bus1.rd_cmd = rd_cmd;
  assign bus0.busy_clr = busy_clr; assign bus1.busy_clr = busy_clr;
  assign bus0.irq_src = irq;     assign bus1.irq_src = irq;
  assign bus0.ack = ack;         assign bus1.ack = ack;

  snd_cmd_mailbox #(.DW(8), .DEPTH(DEPTH), .NIRQ(1), .BUSY_MODE(0)) dut0 (
    .clk(clk), .RESETn(rstn), .bus(bus0));
  snd_cmd_mailbox #(.DW(8), .DEPTH(DEPTH), .NIRQ(1), .BUSY_MODE(1)) dut1 (
    .clk(clk), .RESETn(rstn), .bus(bus1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Spec-level model: a bounded queue of commands plus flag bits.
  task automatic model_step();
    logic e_m, e_i, pop, push, o, rearm;
    if (!rstn) begin
      mq.delete();
      m_pend = 2'b00; m_busy = 1'b0; m_ovf = 1'b0; m_hm = 1'b1; m_hirq = 1'b1;
    end else begin
      e_m   = mcode && !m_hm;
      e_i   = irq && !m_hirq;
      pop   = rd_cmd && (mq.size() > 0);
      push  = e_m && ((mq.size() < DEPTH) || pop);
      o     = e_m && !push;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(mdin);
      rearm = pop && (mq.size() > 0);
      m_pend = (m_pend & ~ack) | {e_i, push | rearm};
      m_busy = push | (m_busy & ~busy_clr);
      m_ovf  = o | (m_ovf & ~busy_clr);
      m_hm   = mcode;
      m_hirq = irq;
    end
  endtask

  task automatic check_all();
    logic [7:0] hd;
    hd = (mq.size() > 0) ? mq[0] : 8'hFF;
    chk("dout0",  32'(bus0.cmd_dout),  32'(hd));
    chk("dout1",  32'(bus1.cmd_dout),  32'(hd));
    chk("valid0", 32'(bus0.cmd_valid), 32'(mq.size() > 0));
    chk("count0", 32'(bus0.cmd_count), 32'(mq.size()));
    chk("count1", 32'(bus1.cmd_count), 32'(mq.size()));
    chk("pend0",  32'(bus0.pending),   32'(m_pend));
    chk("pend1",  32'(bus1.pending),   32'(m_pend));
    chk("intn0",  32'(bus0.int_n),     32'(m_pend == 2'b00));
    chk("busy0",  32'(bus0.snd_busy),  32'(m_busy));
    chk("busy1",  32'(bus1.snd_busy),  32'(mq.size() > 0));
    chk("ovf0",   32'(bus0.ovf),       32'(m_ovf));
    chk("ovf1",   32'(bus1.ovf),       32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic push(input logic [7:0] d);
    mdin = d; mcode = 1'b1; step();
    mcode = 1'b0; step();
  endtask

  task automatic pop();
    rd_cmd = 1'b1; step();
    rd_cmd = 1'b0;
  endtask

  initial begin
    // Reset state
    rstn = 1'b0;
    repeat (3) step();
    chk("rst_dout", 32'(bus0.cmd_dout), 32'hFF);
    chk("rst_intn", 32'(bus0.int_n), 32'd1);
    rstn = 1'b1; step();

    // Single push, then ack+pop, then busy_clr
    mdin = 8'h5A; mcode = 1'b1; step();
    chk("t1_dout", 32'(bus0.cmd_dout), 32'h5A);
    chk("t1_intn", 32'(bus0.int_n), 32'd0);
    chk("t1_busy", 32'(bus0.snd_busy), 32'd1);
    mcode = 1'b0; ack = 2'b01; rd_cmd = 1'b1; step();
    chk("t1_intn_clr", 32'(bus0.int_n), 32'd1);
    ack = 2'b00; rd_cmd = 1'b0; busy_clr = 1'b1; step();
    chk("t1_busy_clr", 32'(bus0.snd_busy), 32'd0);
    busy_clr = 1'b0;

    // Fill and overflow
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("fill_count", 32'(bus0.cmd_count), 32'd4);
    chk("fill_ovf", 32'(bus0.ovf), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("fill_order", 32'(bus0.cmd_dout), 32'(i));
      pop();
    end
    busy_clr = 1'b1; step(); busy_clr = 1'b0;
    chk("ovf_clr", 32'(bus0.ovf), 32'd0);

    // Push and pop together at full, then at empty
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    mdin = 8'h34; mcode = 1'b1; rd_cmd = 1'b1; step();
    chk("full_pp_count", 32'(bus0.cmd_count), 32'd4);
    chk("full_pp_ovf", 32'(bus0.ovf), 32'd0);
    chk("full_pp_head", 32'(bus0.cmd_dout), 32'h31);
    mcode = 1'b0; rd_cmd = 1'b0; step();
    repeat (4) pop();
    mdin = 8'h77; mcode = 1'b1; rd_cmd = 1'b1; step();
    chk("empty_pp_count", 32'(bus0.cmd_count), 32'd1);
    mcode = 1'b0; rd_cmd = 1'b0; step();
    pop();

    // Re-arm
    push(8'h11); push(8'h22);
    ack = 2'b01; step(); ack = 2'b00;
    chk("rearm_intn", 32'(bus0.int_n), 32'd1);
    pop();
    chk("rearm_pend", 32'(bus0.pending), 32'd1);
    chk("rearm_dout", 32'(bus0.cmd_dout), 32'h22);
    ack = 2'b01; step(); ack = 2'b00; pop();

    // IRQ source edges
    irq = 1'b1;
    repeat (10) step();
    chk("irq_set", 32'(bus0.pending), 32'd2);
    ack = 2'b10; step(); ack = 2'b00; step();
    chk("irq_held_clr", 32'(bus0.pending), 32'd0);
    irq = 1'b0; step();
    irq = 1'b1; ack = 2'b10; step();
    chk("irq_ack_race", 32'(bus0.pending), 32'd2);
    ack = 2'b00; irq = 1'b0; step();
    ack = 2'b10; step(); ack = 2'b00;

    // mcode held across reset release
    mcode = 1'b1; mdin = 8'hC3; rstn = 1'b0; step();
    rstn = 1'b1; repeat (3) step();
    chk("rst_hold_count", 32'(bus0.cmd_count), 32'd0);
    mcode = 1'b0; step();

    // Reset in mid-FIFO
    push(8'hA1); push(8'hA2); irq = 1'b1; step();
    rstn = 1'b0; step();
    chk("rst_mid_count", 32'(bus0.cmd_count), 32'd0);
    chk("rst_mid_intn", 32'(bus0.int_n), 32'd1);
    irq = 1'b0; rstn = 1'b1; step();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rstn     = ($urandom_range(0, 127) != 0);
      mcode    = ($urandom_range(0, 2) == 0) ? ~mcode : mcode;
      mdin     = 8'($urandom);
      rd_cmd   = ($urandom_range(0, 3) == 0);
      busy_clr = ($urandom_range(0, 7) == 0);
      irq      = ($urandom_range(0, 3) == 0) ? ~irq : irq;
      ack      = 2'($urandom_range(0, 3)) & {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
